spi_flash_arbiter: RTL and testbench
====================================

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter TCSH, default 4: minimum SCS-high clk cycles between transactions, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid and req1_valid, input, 1 bit each: read request from requester 0 and requester 1.
REQ-006 SHALL have ports req0_addr and req1_addr, input, 24 bits each: flash byte address.
REQ-007 SHALL have ports req0_ready and req1_ready, output, 1 bit each: request accepted this cycle.
REQ-008 SHALL have ports rsp0_valid and rsp1_valid, output, 1 bit each: one-cycle pulse, rsp_data is valid for that requester.
REQ-009 SHALL have port rsp_data, output, 32 bits: read word, shared by both requesters.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have ports SCS, SCLK and MOSI, output, 1 bit each: SPI chip select (active-low), clock and data out to the flash.
REQ-012 SHALL have port MISO, input, 1 bit: SPI data in from the flash.

Function
REQ-013 SHALL implement states IDLE, CMD, ADDR, DATA, CSH.
REQ-014 In IDLE, with any reqN_valid high, SHALL assert exactly one reqN_ready for one cycle, latch that requester's address and ID, and enter CMD on the next edge.
REQ-015 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-016 Both reqN_ready SHALL be low in every state other than IDLE; requests held during busy SHALL wait and never be dropped or duplicated.
REQ-017 SCS SHALL be low from entry to CMD through the end of DATA, and high in IDLE and CSH.
REQ-018 SPI SHALL be mode 0: SCLK idles low; each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-019 MOSI SHALL change only while SCLK is low; the first bit SHALL be valid on entry to CMD.
REQ-020 MISO SHALL be sampled on the clk edge where SCLK goes high.
REQ-021 CMD SHALL shift the 8 bits of 0x03 MSB-first, then go to ADDR.
REQ-022 ADDR SHALL shift the 24 address bits MSB-first (bit 23 first), then go to DATA.
REQ-023 In DATA, MOSI SHALL be held at 0.
REQ-024 DATA SHALL capture 32 bits; byte k (k=0..3, each MSB-first) received SHALL map to rsp_data[8k+7:8k], i.e. little-endian.
REQ-025 A transaction SHALL take exactly 64 SCLK periods, i.e. 128*CLK_DIV clk cycles with SCS low.
REQ-026 On the cycle SCS returns high, rsp_data SHALL update and the matching rspN_valid SHALL pulse for exactly one cycle.
REQ-027 rsp_data SHALL hold its value until the next response.
REQ-028 CSH SHALL last exactly TCSH cycles, then return to IDLE.
REQ-029 Earliest next grant SHALL be the first IDLE cycle; this is back-to-back when a request is already pending.
REQ-030 A 24-bit counter value is not required: bit counter 6 bits (0..63) and divider counter 8 bits; address wrap at 0xFFFFFF is the flash's concern and SHALL need no special handling here.
REQ-031 Changes to reqN_addr after acceptance SHALL have no effect on the transaction in progress.

Reset
REQ-032 With reset low, at any time including mid-transaction, SHALL force: state IDLE, SCS=1, SCLK=0, MOSI=0, reqN_ready=0, rspN_valid=0, rsp_data=0, busy=0, last-grant pointer=1.
REQ-033 An aborted transaction SHALL produce no response.
REQ-034 The first grant SHALL be possible on the first clk edge after reset deasserts.

Verification (CLK_DIV=2, TCSH=4, flash model preloaded with 0x100=11, 0x101=22, 0x102=33, 0x103=44)
REQ-035 req0 at addr 0x000100 -> MOSI stream 0x03,0x00,0x01,0x00; SCS low exactly 256 cycles; rsp0_valid single pulse; rsp_data=0x44332211.
REQ-036 req0 and req1 raised in the same cycle after reset -> req0 granted first, req1 granted on the first IDLE cycle after 4 CSH cycles; rsp0 precedes rsp1.
REQ-037 Both held continuously for 4 transactions -> grant order 0,1,0,1; no ready pulse while busy=1.
REQ-038 reset pulsed low during ADDR -> SCS=1 and SCLK=0 immediately (asynchronously); no rsp pulse; a new req0 afterwards completes with correct data.
REQ-039 SCLK timing checker over all tests -> every high/low phase exactly 2 cycles; MOSI never changes while SCLK=1; SCS high ≥4 cycles between transactions.
REQ-040 req1 addr changed the cycle after acceptance -> transaction uses the latched address; data matches the original address.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// Two-requester SPI flash read arbiter.
// Grants one of two requesters round-robin. For the granted request it issues a
// 0x03 READ command, a 24-bit address and 32 data clocks in SPI mode 0, then
// returns the word little-endian with a one-cycle rspN_valid pulse.
// Ports:
//   clk, reset (async, active-low)
//   reqN_valid/reqN_addr/reqN_ready : request handshakes (ready is combinational)
//   rspN_valid, rsp_data            : response pulse and shared read word
//   busy                            : high whenever the FSM is not in IDLE
//   SCS, SCLK, MOSI, MISO           : SPI flash pins
module spi_flash_arbiter #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned TCSH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        SCS,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned SHIFT_W = 32;

  localparam logic [7:0]       CMD_READ  = 8'h03;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] TCSH_LAST = DIV_W'(TCSH - 1);
  localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(7);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(31);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(63);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, CSH} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q;
  logic [SHIFT_W-1:0]   tx_q, tx_d;
  logic [SHIFT_W-1:0]   rx_q;
  logic [31:0]          rsp_data_q;
  logic                 sclk_q, scs_q, busy_q, mosi_q;
  logic                 rsp0_q, rsp1_q;
  logic                 last_q, id_q;
  logic                 active, tick, rise, fall;
  logic                 grant, grant_id;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, arbitration, SCLK phase decode and transmit shifter
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    div_d    = div_q;
    active   = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    tick     = active && (div_q == DIV_LAST);
    rise     = tick && !sclk_q;
    fall     = tick && sclk_q;
    // reset gates the grant so ready stays low while reset is held
    grant    = (state_q == IDLE) && reset && (req0_valid || req1_valid);
    grant_id = (req0_valid && req1_valid) ? !last_q : req1_valid;

    if (grant)     tx_d = {CMD_READ, (grant_id ? req1_addr : req0_addr)};
    else if (fall) tx_d = {tx_q[SHIFT_W-2:0], 1'b0};

    case (state_q)
      IDLE: if (grant)                       state_d = CMD;
      CMD:  if (fall && bit_q == CMD_LAST)   state_d = ADDR;
      ADDR: if (fall && bit_q == ADDR_LAST)  state_d = DATA;
      DATA: if (fall && bit_q == DATA_LAST)  state_d = CSH;
      CSH:  if (div_q == TCSH_LAST)          state_d = IDLE;
      default:                               state_d = IDLE;
    endcase

    // One counter times SCLK half-periods in the active states and the CSH gap
    if (tick || state_d != state_q) div_d = '0;
    else if (state_q != IDLE)       div_d = div_q + DIV_W'(1);
  end

  // Datapath and registered SPI/status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rsp_data_q <= '0;
      sclk_q     <= 1'b0;
      scs_q      <= 1'b1;
      busy_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
    end else begin
      div_q  <= div_d;
      tx_q   <= tx_d;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      if (tick) sclk_q <= !sclk_q;
      if (grant)     bit_q <= '0;
      else if (fall) bit_q <= bit_q + BIT_W'(1);
      // MISO sampled on the edge that raises SCLK
      if (rise) rx_q <= {rx_q[SHIFT_W-2:0], MISO};
      if (grant) begin
        id_q   <= grant_id;
        last_q <= grant_id;
      end
      // First received byte lands in the low byte of rsp_data
      if (state_q == DATA && state_d == CSH) begin
        rsp_data_q <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
        rsp0_q     <= !id_q;
        rsp1_q     <= id_q;
      end
      scs_q  <= !((state_d == CMD) || (state_d == ADDR) || (state_d == DATA));
      busy_q <= (state_d != IDLE);
      mosi_q <= ((state_d == CMD) || (state_d == ADDR)) && tx_d[SHIFT_W-1];
    end
  end

  assign req0_ready = grant && !grant_id;
  assign req1_ready = grant && grant_id;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_q;
  assign SCS        = scs_q;
  assign SCLK       = sclk_q;
  assign MOSI       = mosi_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Self-checking bench for spi_flash_arbiter with a behavioural SPI read flash.
module tb_spi_flash_arbiter;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned TCSH    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0] req0_addr = '0, req1_addr = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp_data;
  logic        SCS, SCLK, MOSI;
  logic        MISO = 1'b0;

  always #5 clk = ~clk;

  spi_flash_arbiter #(.CLK_DIV(CLK_DIV), .TCSH(TCSH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .busy(busy), .SCS(SCS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Flash contents
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      24'h000200: return 8'h55;
      24'h000201: return 8'h66;
      24'h000202: return 8'h77;
      24'h000203: return 8'h88;
      24'hFFFFFC: return 8'hDE;
      24'hFFFFFD: return 8'hAD;
      24'hFFFFFE: return 8'hBE;
      24'hFFFFFF: return 8'hEF;
      24'h000000: return 8'h5A;
      24'h000001: return 8'hC3;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16];
    endcase
  endfunction

  // Flash model: collects cmd+addr on SCLK rise, drives data on SCLK fall
  int          fl_n = 0;
  int          fl_idx;
  logic [31:0] fl_in = '0;
  logic [23:0] fl_addr = '0;
  logic [7:0]  fl_b;
  logic [31:0] cmd_q[$];

  always @(negedge SCS) fl_n = 0;

  always @(posedge SCLK) begin
    if (!SCS) begin
      if (fl_n < 32) fl_in = {fl_in[30:0], MOSI};
      fl_n++;
      if (fl_n == 32) begin
        cmd_q.push_back(fl_in);
        fl_addr = fl_in[23:0];
      end
    end
  end

  always @(negedge SCLK) begin
    if (!SCS && fl_n >= 32 && fl_n < 64) begin
      fl_idx = fl_n - 32;
      fl_b   = flash_byte(fl_addr + 24'(fl_idx / 8));
      MISO   = fl_b[7 - (fl_idx % 8)];
    end
  end

  // Bus monitor: grants, responses, SCLK/SCS timing, MOSI stability
  int          grant_q[$];
  int          gcyc_q[$];
  int          rsp_id_q[$];
  logic [31:0] rsp_dat_q[$];
  int          cyc = 0;
  int          sclk_lo = 0, sclk_hi = 0, scs_lo = 0, scs_hi = 0;
  logic        prev_sclk = 1'b0, prev_scs = 1'b1, prev_mosi = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      sclk_lo = 0;
      sclk_hi = 0;
      scs_lo  = 0;
      if (SCS) scs_hi++;
    end else begin
      if (req0_ready && req1_ready) chk("dual_ready", 32'd1, 32'd0);
      if (req0_ready) begin
        grant_q.push_back(0);
        gcyc_q.push_back(cyc);
        chk("ready0_while_busy", 32'(busy), 32'd0);
      end
      if (req1_ready) begin
        grant_q.push_back(1);
        gcyc_q.push_back(cyc);
        chk("ready1_while_busy", 32'(busy), 32'd0);
      end
      if (rsp0_valid || rsp1_valid || (!prev_scs && SCS))
        chk("rsp_pulse_at_scs_rise", 32'(rsp0_valid ^ rsp1_valid), 32'(!prev_scs && SCS));
      if (rsp0_valid) begin rsp_id_q.push_back(0); rsp_dat_q.push_back(rsp_data); end
      if (rsp1_valid) begin rsp_id_q.push_back(1); rsp_dat_q.push_back(rsp_data); end

      if (!prev_scs && SCS) begin
        chk("scs_low_cycles", 32'(scs_lo), 32'd256);
        scs_lo = 0;
      end
      if (prev_scs && !SCS) begin
        chk("scs_high_gap_ge4", 32'(scs_hi >= 4), 32'd1);
        scs_hi = 0;
      end
      if (!SCS) scs_lo++;
      else      scs_hi++;

      if (SCLK && !prev_sclk) begin
        chk("sclk_low_phase", 32'(sclk_lo), 32'(CLK_DIV));
        sclk_lo = 0;
      end
      if (!SCLK && prev_sclk) begin
        chk("sclk_high_phase", 32'(sclk_hi), 32'(CLK_DIV));
        sclk_hi = 0;
      end
      if (SCLK)      sclk_hi++;
      else if (!SCS) sclk_lo++;

      if (SCLK && prev_sclk) chk("mosi_stable_sclk_high", 32'(MOSI), 32'(prev_mosi));
      if (SCS && (SCLK || MOSI)) chk("spi_idle_levels", {30'd0, SCLK, MOSI}, 32'd0);
    end
    prev_sclk = SCLK;
    prev_scs  = SCS;
    prev_mosi = MOSI;
  end

  // Single request from one requester, checked end to end
  task automatic do_txn(input logic id, input logic [23:0] addr, input logic [31:0] exp_data,
                        input logic [31:0] exp_cmd, input logic change_addr);
    int g0, r0, c0, k;
    g0 = grant_q.size();
    r0 = rsp_id_q.size();
    c0 = cmd_q.size();
    @(posedge clk); #1;
    if (id) begin req1_addr = addr; req1_valid = 1'b1; end
    else    begin req0_addr = addr; req0_valid = 1'b1; end
    k = 0;
    while (grant_q.size() == g0 && k < 50) begin @(posedge clk); k++; end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (change_addr) begin req0_addr = ~addr; req1_addr = ~addr; end
    chk("txn_granted", 32'(grant_q.size() > g0), 32'd1);
    chk("txn_grant_id", 32'(grant_q[$]), 32'(id));
    k = 0;
    while (rsp_id_q.size() == r0 && k < 400) begin @(posedge clk); k++; end
    chk("txn_rsp_seen", 32'(rsp_id_q.size() == r0 + 1), 32'd1);
    chk("txn_rsp_id", 32'(rsp_id_q[$]), 32'(id));
    chk("txn_rsp_data", rsp_dat_q[$], exp_data);
    chk("txn_cmd_count", 32'(cmd_q.size()), 32'(c0 + 1));
    chk("txn_mosi_stream", cmd_q[$], exp_cmd);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("txn_rsp_hold", rsp_data, exp_data);
    chk("txn_idle_busy", 32'(busy), 32'd0);
  endtask

  // Both requesters held until `total` grants have been made
  task automatic run_both(input int total, input int g0, input int r0);
    int k;
    k = 0;
    while (grant_q.size() < g0 + total && k < 3000) begin @(posedge clk); k++; end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("both_grants_made", 32'(grant_q.size() == g0 + total), 32'd1);
    k = 0;
    while (rsp_id_q.size() < r0 + total && k < 3000) begin @(posedge clk); k++; end
    chk("both_rsps_made", 32'(rsp_id_q.size() == r0 + total), 32'd1);
    repeat (6) @(posedge clk);
  endtask

  typedef struct {
    logic        id;
    logic [23:0] addr;
    logic [31:0] exp_data;
    logic [31:0] exp_cmd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, r0, c0;
    vecs[0] = '{1'b0, 24'h000100, 32'h44332211, 32'h03000100};
    vecs[1] = '{1'b1, 24'h000200, 32'h88776655, 32'h03000200};
    vecs[2] = '{1'b0, 24'hFFFFFC, 32'hEFBEADDE, 32'h03FFFFFC};
    vecs[3] = '{1'b1, 24'hFFFFFE, 32'hC35AEFBE, 32'h03FFFFFE};
    vecs[4] = '{1'b0, 24'h800001, 32'h84838281, 32'h03800001};
    vecs[5] = '{1'b1, 24'h123456, 32'h7F7E7170, 32'h03123456};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_scs", 32'(SCS), 32'd1);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);

    // Simultaneous requests raised while in reset
    req0_addr  = 24'h000100;
    req1_addr  = 24'h000200;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_ready_gated", {30'd0, req1_ready, req0_ready}, 32'd0);
    g0 = grant_q.size();
    r0 = rsp_id_q.size();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("first_grant_after_reset", {30'd0, req1_ready, req0_ready}, 32'd1);
    run_both(2, g0, r0);
    chk("tie_grant0", 32'(grant_q[g0]), 32'd0);
    chk("tie_grant1", 32'(grant_q[g0 + 1]), 32'd1);
    chk("tie_backtoback_gap", 32'(gcyc_q[g0 + 1] - gcyc_q[g0]), 32'd261);
    chk("tie_rsp_order0", 32'(rsp_id_q[r0]), 32'd0);
    chk("tie_rsp_order1", 32'(rsp_id_q[r0 + 1]), 32'd1);
    chk("tie_rsp_data0", rsp_dat_q[r0], 32'h44332211);
    chk("tie_rsp_data1", rsp_dat_q[r0 + 1], 32'h88776655);

    // Both held for four transactions: round-robin alternation
    g0 = grant_q.size();
    r0 = rsp_id_q.size();
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    run_both(4, g0, r0);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant_order", 32'(grant_q[g0 + i]), 32'(i % 2));
      chk("rr_rsp_order", 32'(rsp_id_q[r0 + i]), 32'(i % 2));
      chk("rr_rsp_data", rsp_dat_q[r0 + i], (i % 2 == 0) ? 32'h44332211 : 32'h88776655);
    end
    for (int i = 1; i < 4; i++)
      chk("rr_gap", 32'(gcyc_q[g0 + i] - gcyc_q[g0 + i - 1]), 32'd261);

    // Table of single transactions
    for (int i = 0; i < 6; i++)
      do_txn(vecs[i].id, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_cmd, 1'b0);

    // Reset pulsed during ADDR aborts without a response
    g0 = grant_q.size();
    c0 = cmd_q.size();
    @(posedge clk); #1;
    req0_addr  = 24'h000100;
    req0_valid = 1'b1;
    while (grant_q.size() == g0) @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_scs_async", 32'(SCS), 32'd1);
    chk("abort_sclk_async", 32'(SCLK), 32'd0);
    chk("abort_mosi", 32'(MOSI), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_data_cleared", rsp_data, 32'd0);
    r0 = rsp_id_q.size();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (300) @(posedge clk);
    chk("abort_no_rsp", 32'(rsp_id_q.size()), 32'(r0));
    chk("abort_no_full_cmd", 32'(cmd_q.size()), 32'(c0));
    do_txn(1'b0, 24'h000100, 32'h44332211, 32'h03000100, 1'b0);

    // Address changed right after acceptance is ignored
    do_txn(1'b1, 24'h000200, 32'h88776655, 32'h03000200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
